marks_bank: RTL

// - Multi-section successor of the single-section marks register: holds NUM_SECTIONS independent

---
 rtl/marks_bank.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/marks_bank.sv
// Multi-section mark store with a sequential wrap-around search for the first unmarked position.
// Optional per-section population counters are compiled in when MARKS_COUNT_EN is defined.
module marks_bank #(
  parameter int SECTION_SIZE = 19,
  parameter int NUM_SECTIONS = 4,
  parameter int SEC_W        = 2,
  parameter int IDX_W        = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 upd_valid,
  output logic                                 upd_ready,
  input  logic                                 upd_clear,
  input  logic [SEC_W-1:0]                     upd_section,
  input  logic [3:0]                           upd_num_window,
  input  logic [2:0]                           upd_window_position,
  output logic                                 upd_err,
  input  logic                                 scan_start,
  input  logic [SEC_W-1:0]                     scan_section,
  input  logic [IDX_W-1:0]                     scan_from,
  output logic                                 scan_done,
  output logic                                 scan_found,
  output logic [IDX_W-1:0]                     scan_index,
  output logic [IDX_W:0]                       mark_count,
  output logic [NUM_SECTIONS*SECTION_SIZE-1:0] marks
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_DONE = 2'd2} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTION_SIZE - 1);

  state_t                  state_r, state_nxt_s;
  logic [SECTION_SIZE-1:0] mem_r [NUM_SECTIONS];
  logic [SEC_W-1:0]        sec_r;
  logic                    sec_ok_r;
  logic [IDX_W-1:0]        from_r, ptr_r, steps_r, index_r;
  logic                    found_r, done_r, err_r, ready_r;
  logic [4:0]              upd_idx_s;
  logic                    upd_fire_s, upd_ok_s, scan_sec_ok_s, cur_bit_s, last_step_s;
  logic [IDX_W-1:0]        scan_from_eff_s;

  assign upd_idx_s       = {1'b0, upd_num_window} + {2'b00, upd_window_position};
  assign upd_fire_s      = upd_valid && (state_r == ST_IDLE);
  assign upd_ok_s        = (int'(upd_section) < NUM_SECTIONS) && (int'(upd_idx_s) < SECTION_SIZE);
  assign scan_sec_ok_s   = int'(scan_section) < NUM_SECTIONS;
  assign scan_from_eff_s = (int'(scan_from) < SECTION_SIZE) ? scan_from : {IDX_W{1'b0}};
  assign cur_bit_s       = mem_r[sec_r][ptr_r];
  assign last_step_s     = (steps_r == LAST_IDX);

  assign upd_ready  = ready_r;
  assign upd_err    = err_r;
  assign scan_done  = done_r;
  assign scan_found = found_r;
  assign scan_index = index_r;

  for (genvar g = 0; g < NUM_SECTIONS; g++) begin : g_marks
    assign marks[g*SECTION_SIZE +: SECTION_SIZE] = mem_r[g];
  end

  // Scan FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (scan_start) begin
          state_nxt_s = scan_sec_ok_s ? ST_SCAN : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!cur_bit_s || last_step_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus handshake/pulse outputs derived from it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      done_r  <= (state_r == ST_DONE);
      err_r   <= upd_fire_s && !upd_ok_s;
    end
  end

  // Mark storage; out-of-range updates complete the handshake but leave marks untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SECTIONS; s++) mem_r[s] <= {SECTION_SIZE{1'b0}};
    end else if (upd_fire_s && upd_ok_s) begin
      mem_r[upd_section][upd_idx_s] <= !upd_clear;
    end
  end

  // Scan pointer, step counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_r    <= {SEC_W{1'b0}};
      sec_ok_r <= 1'b0;
      from_r   <= {IDX_W{1'b0}};
      ptr_r    <= {IDX_W{1'b0}};
      steps_r  <= {IDX_W{1'b0}};
      found_r  <= 1'b0;
      index_r  <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (scan_start) begin
            sec_r    <= scan_section;
            sec_ok_r <= scan_sec_ok_s;
            from_r   <= scan_from_eff_s;
            ptr_r    <= scan_from_eff_s;
            steps_r  <= {IDX_W{1'b0}};
            if (!scan_sec_ok_s) begin
              found_r <= 1'b0;
              index_r <= scan_from_eff_s;
            end
          end
        end
        ST_SCAN: begin
          if (!cur_bit_s) begin
            found_r <= 1'b1;
            index_r <= ptr_r;
          end else if (last_step_s) begin
            found_r <= 1'b0;
            index_r <= from_r;
          end else begin
            ptr_r   <= (ptr_r == LAST_IDX) ? {IDX_W{1'b0}} : ptr_r + IDX_W'(1);
            steps_r <= steps_r + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MARKS_COUNT_EN
  logic [IDX_W:0] cnt_r [NUM_SECTIONS];
  logic [IDX_W:0] count_r;

  // Population counters only move when the addressed bit actually changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SECTIONS; s++) cnt_r[s] <= {(IDX_W+1){1'b0}};
    end else if (upd_fire_s && upd_ok_s) begin
      if (upd_clear && mem_r[upd_section][upd_idx_s]) begin
        cnt_r[upd_section] <= cnt_r[upd_section] - (IDX_W+1)'(1);
      end else if (!upd_clear && !mem_r[upd_section][upd_idx_s]) begin
        cnt_r[upd_section] <= cnt_r[upd_section] + (IDX_W+1)'(1);
      end
    end
  end

  // Snapshot of the scanned section's count, taken as the scan completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {(IDX_W+1){1'b0}};
    end else if (state_r == ST_DONE) begin
      count_r <= sec_ok_r ? cnt_r[sec_r] : {(IDX_W+1){1'b0}};
    end
  end

  assign mark_count = count_r;
`else
  assign mark_count = {(IDX_W+1){1'b0}};
`endif

endmodule
